// File: rtl/mul_arbiter.sv
// ============================================================================
// Module   : mul_arbiter
// Purpose  : Round-robin sequencer for two requesters sharing one iterative
//            shift-add multiplier; returns the full 2*WIDTH product.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_arbiter #(
  parameter int WIDTH = 12
) (
  input  logic               clock_i,
  input  logic               nreset_i,
  input  logic               req0_valid_i,
  input  logic [WIDTH-1:0]   req0_a_i,
  input  logic [WIDTH-1:0]   req0_b_i,
  output logic               req0_ready_o,
  input  logic               req1_valid_i,
  input  logic [WIDTH-1:0]   req1_a_i,
  input  logic [WIDTH-1:0]   req1_b_i,
  output logic               req1_ready_o,
  output logic               rsp0_valid_o,
  output logic               rsp1_valid_o,
  input  logic               rsp0_ready_i,
  input  logic               rsp1_ready_i,
  output logic [2*WIDTH-1:0] rsp_data_o,
  output logic               busy_o
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_prod;
  logic             r_owner;
  logic             r_last_grant;

  logic             w_idle;
  logic             w_sel1;
  logic             w_accept;
  logic             w_rsp_fire;
  logic [WIDTH-1:0] w_a_in;
  logic [WIDTH-1:0] w_b_in;

  // Port 1 wins when it is the only requester, or on a tie when port 0 went last.
  assign w_idle       = (r_state == ST_IDLE);
  assign w_sel1       = req1_valid_i && (!req0_valid_i || !r_last_grant);
  assign req0_ready_o = w_idle && req0_valid_i && !w_sel1;
  assign req1_ready_o = w_idle && w_sel1;
  assign w_accept     = (req0_valid_i && req0_ready_o) || (req1_valid_i && req1_ready_o);
  assign w_a_in       = w_sel1 ? req1_a_i : req0_a_i;
  assign w_b_in       = w_sel1 ? req1_b_i : req0_b_i;

  assign w_rsp_fire   = r_owner ? rsp1_ready_i : rsp0_ready_i;
  assign rsp0_valid_o = (r_state == ST_DONE) && !r_owner;
  assign rsp1_valid_o = (r_state == ST_DONE) && r_owner;
  assign rsp_data_o   = r_prod;
  assign busy_o       = !w_idle;

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)     w_state_nxt = ST_CALC;
      ST_CALC: if (r_b == '0)    w_state_nxt = ST_DONE;
      ST_DONE: if (w_rsp_fire)   w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_a          <= '0;
      r_b          <= '0;
      r_prod       <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= {{WIDTH{1'b0}}, w_a_in};
            r_b     <= w_b_in;
            r_prod  <= '0;
            r_owner <= w_sel1;
          end
        end
        ST_CALC: begin
          // Early termination: stop as soon as no multiplier bits remain.
          if (r_b != '0) begin
            if (r_b[0]) begin
              r_prod <= r_prod + r_a;
            end
            r_a <= r_a << 1;
            r_b <= r_b >> 1;
          end
        end
        ST_DONE: begin
          if (w_rsp_fire) begin
            r_last_grant <= r_owner;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_arbiter.sv
// ============================================================================
// Module   : tb_mul_arbiter
// Purpose  : Directed self-checking bench for mul_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_arbiter;

  logic        clock_i = 1'b0;
  logic        nreset_i;
  logic        req0_valid_i, req1_valid_i;
  logic [11:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
  logic        req0_ready_o, req1_ready_o;
  logic        rsp0_valid_o, rsp1_valid_o;
  logic        rsp0_ready_i, rsp1_ready_i;
  logic [23:0] rsp_data_o;
  logic        busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  mul_arbiter #(.WIDTH(12)) dut (
    .clock_i      (clock_i),
    .nreset_i     (nreset_i),
    .req0_valid_i (req0_valid_i),
    .req0_a_i     (req0_a_i),
    .req0_b_i     (req0_b_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_a_i     (req1_a_i),
    .req1_b_i     (req1_b_i),
    .req1_ready_o (req1_ready_o),
    .rsp0_valid_o (rsp0_valid_o),
    .rsp1_valid_o (rsp1_valid_o),
    .rsp0_ready_i (rsp0_ready_i),
    .rsp1_ready_i (rsp1_ready_i),
    .rsp_data_o   (rsp_data_o),
    .busy_o       (busy_o)
  );

  always #5 clock_i = ~clock_i;

  // Drives one request, then waits (bounded) for its response; lat counts the accept edge as 1.
  task automatic issue(input bit port, input logic [11:0] a, input logic [11:0] b,
                       output bit rdy, output int lat, output bit other, output bit busy_ok);
    @(negedge clock_i);
    if (port) begin req1_valid_i = 1'b1; req1_a_i = a; req1_b_i = b; end
    else      begin req0_valid_i = 1'b1; req0_a_i = a; req0_b_i = b; end
    #1 rdy = port ? req1_ready_o : req0_ready_o;
    @(posedge clock_i); #1;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    lat = 1; other = 1'b0; busy_ok = 1'b1;
    while (!(port ? rsp1_valid_o : rsp0_valid_o) && lat < 30) begin
      if (!busy_o) busy_ok = 1'b0;
      if (port ? rsp0_valid_o : rsp1_valid_o) other = 1'b1;
      @(posedge clock_i); #1;
      lat++;
    end
    if (port ? rsp0_valid_o : rsp1_valid_o) other = 1'b1;
  endtask

  task automatic finish_rsp(input bit port);
    if (port) rsp1_ready_i = 1'b1; else rsp0_ready_i = 1'b1;
    @(posedge clock_i); #1;
    rsp0_ready_i = 1'b0;
    rsp1_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    nreset_i = 1'b0;
    #12;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o); else n_pass++;
    n_checks++; if ({rsp0_valid_o, rsp1_valid_o} !== 2'b00) $display("FAIL reset_rsp_valid: got %b expected 00", {rsp0_valid_o, rsp1_valid_o}); else n_pass++;
    n_checks++; if ({req0_ready_o, req1_ready_o} !== 2'b00) $display("FAIL reset_ready: got %b expected 00", {req0_ready_o, req1_ready_o}); else n_pass++;
    n_checks++; if (rsp_data_o !== 24'd0) $display("FAIL reset_data: got %0d expected 0", rsp_data_o); else n_pass++;
    @(negedge clock_i);
    nreset_i = 1'b1;
  endtask

  task automatic test_single();
    bit rdy, other, bok; int lat;
    issue(1'b0, 12'd3, 12'd5, rdy, lat, other, bok);
    n_checks++; if (rdy !== 1'b1) $display("FAIL single_ready0: got %b expected 1", rdy); else n_pass++;
    n_checks++; if (lat != 5) $display("FAIL single_latency: got %0d expected 5", lat); else n_pass++;
    n_checks++; if (rsp_data_o !== 24'd15) $display("FAIL single_data: got %0d expected 15", rsp_data_o); else n_pass++;
    n_checks++; if (other !== 1'b0) $display("FAIL single_rsp1_quiet: got %b expected 0", other); else n_pass++;
    finish_rsp(1'b0);
    n_checks++; if ({busy_o, rsp0_valid_o} !== 2'b00) $display("FAIL single_release: got %b expected 00", {busy_o, rsp0_valid_o}); else n_pass++;
  endtask

  task automatic test_zero();
    bit rdy, other, bok; int lat;
    issue(1'b0, 12'd1234, 12'd0, rdy, lat, other, bok);
    n_checks++; if (lat != 2) $display("FAIL zero_b_latency: got %0d expected 2", lat); else n_pass++;
    n_checks++; if (rsp_data_o !== 24'd0) $display("FAIL zero_b_data: got %0d expected 0", rsp_data_o); else n_pass++;
    finish_rsp(1'b0);
    issue(1'b0, 12'd0, 12'd4095, rdy, lat, other, bok);
    n_checks++; if (lat != 14) $display("FAIL zero_a_latency: got %0d expected 14", lat); else n_pass++;
    n_checks++; if (rsp_data_o !== 24'd0) $display("FAIL zero_a_data: got %0d expected 0", rsp_data_o); else n_pass++;
    finish_rsp(1'b0);
  endtask

  task automatic test_max();
    bit rdy, other, bok; int lat;
    issue(1'b1, 12'd4095, 12'd4095, rdy, lat, other, bok);
    n_checks++; if (rdy !== 1'b1) $display("FAIL max_ready1: got %b expected 1", rdy); else n_pass++;
    n_checks++; if (lat != 14) $display("FAIL max_latency: got %0d expected 14", lat); else n_pass++;
    n_checks++; if (rsp_data_o !== 24'd16769025) $display("FAIL max_data: got %0d expected 16769025", rsp_data_o); else n_pass++;
    n_checks++; if (bok !== 1'b1 || busy_o !== 1'b1) $display("FAIL max_busy: got %b/%b expected 1/1", bok, busy_o); else n_pass++;
    n_checks++; if (other !== 1'b0) $display("FAIL max_rsp0_quiet: got %b expected 0", other); else n_pass++;
    finish_rsp(1'b1);
    n_checks++; if (busy_o !== 1'b0) $display("FAIL max_busy_release: got %b expected 0", busy_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int g[4];
    int ng = 0, nr = 0, bad_ovl = 0, bad_rsp = 0, cyc = 0;
    @(negedge clock_i);
    req0_valid_i = 1'b1; req0_a_i = 12'd2; req0_b_i = 12'd3;
    req1_valid_i = 1'b1; req1_a_i = 12'd5; req1_b_i = 12'd7;
    rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) g[i] = -1;
    while ((ng < 4 || nr < 4) && cyc < 200) begin
      #1;
      if (req0_ready_o && req1_ready_o) bad_ovl++;
      if ((req0_ready_o || req1_ready_o) && busy_o) bad_ovl++;
      if (ng < 4 && req0_ready_o) begin g[ng] = 0; ng++; end
      else if (ng < 4 && req1_ready_o) begin g[ng] = 1; ng++; end
      if (rsp0_valid_o) begin
        if (rsp1_valid_o || rsp_data_o !== 24'd6) bad_rsp++;
        nr++;
      end else if (rsp1_valid_o) begin
        if (rsp_data_o !== 24'd35) bad_rsp++;
        nr++;
      end
      if (ng < 4 || nr < 4) @(negedge clock_i);
      cyc++;
    end
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    @(posedge clock_i); #1;
    rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
    n_checks++; if (g[0] != 0 || g[1] != 1 || g[2] != 0 || g[3] != 1)
      $display("FAIL b2b_grant_order: got %0d,%0d,%0d,%0d expected 0,1,0,1", g[0], g[1], g[2], g[3]); else n_pass++;
    n_checks++; if (nr != 4) $display("FAIL b2b_rsp_count: got %0d expected 4", nr); else n_pass++;
    n_checks++; if (bad_rsp != 0) $display("FAIL b2b_rsp_data: got %0d bad expected 0", bad_rsp); else n_pass++;
    n_checks++; if (bad_ovl != 0) $display("FAIL b2b_ready_overlap: got %0d bad expected 0", bad_ovl); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL b2b_idle: got %b expected 0", busy_o); else n_pass++;
  endtask

  task automatic test_hold();
    bit rdy, other, bok; int lat; int bad = 0;
    issue(1'b0, 12'd7, 12'd9, rdy, lat, other, bok);
    n_checks++; if (lat != 6) $display("FAIL hold_latency: got %0d expected 6", lat); else n_pass++;
    req1_valid_i = 1'b1; req1_a_i = 12'd2; req1_b_i = 12'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock_i);
      if (!rsp0_valid_o || rsp1_valid_o || rsp_data_o !== 24'd63 || req1_ready_o || req0_ready_o) bad++;
      rsp1_ready_i = ~rsp1_ready_i;
    end
    rsp1_ready_i = 1'b0;
    req1_valid_i = 1'b0;
    n_checks++; if (bad != 0) $display("FAIL hold_stable: got %0d bad cycles expected 0", bad); else n_pass++;
    n_checks++; if (rsp_data_o !== 24'd63) $display("FAIL hold_data: got %0d expected 63", rsp_data_o); else n_pass++;
    rsp0_ready_i = 1'b1;
    @(posedge clock_i); #1;
    rsp0_ready_i = 1'b0;
    n_checks++; if ({busy_o, rsp0_valid_o} !== 2'b00) $display("FAIL hold_release: got %b expected 00", {busy_o, rsp0_valid_o}); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit rdy, other, bok; int lat; int w;
    @(negedge clock_i);
    req0_valid_i = 1'b1; req0_a_i = 12'd100; req0_b_i = 12'd200;
    @(posedge clock_i); #1;
    req0_valid_i = 1'b0;
    repeat (3) @(posedge clock_i);
    #2 nreset_i = 1'b0;
    #1;
    n_checks++; if ({busy_o, rsp0_valid_o, rsp1_valid_o} !== 3'b000) $display("FAIL rst_calc_async: got %b expected 000", {busy_o, rsp0_valid_o, rsp1_valid_o}); else n_pass++;
    @(negedge clock_i);
    nreset_i = 1'b1;
    issue(1'b1, 12'd100, 12'd200, rdy, lat, other, bok);
    n_checks++; if (rdy !== 1'b1) $display("FAIL rst_p1_ready: got %b expected 1", rdy); else n_pass++;
    n_checks++; if (lat != 10) $display("FAIL rst_p1_latency: got %0d expected 10", lat); else n_pass++;
    n_checks++; if (rsp_data_o !== 24'd20000) $display("FAIL rst_p1_data: got %0d expected 20000", rsp_data_o); else n_pass++;
    #2 nreset_i = 1'b0;
    #1;
    n_checks++; if ({busy_o, rsp1_valid_o} !== 2'b00) $display("FAIL rst_done_async: got %b expected 00", {busy_o, rsp1_valid_o}); else n_pass++;
    @(negedge clock_i);
    nreset_i = 1'b1;
    @(negedge clock_i);
    req0_valid_i = 1'b1; req0_a_i = 12'd2; req0_b_i = 12'd3;
    req1_valid_i = 1'b1; req1_a_i = 12'd5; req1_b_i = 12'd7;
    #1;
    n_checks++; if ({req0_ready_o, req1_ready_o} !== 2'b10) $display("FAIL rst_tie_grant: got %b expected 10", {req0_ready_o, req1_ready_o}); else n_pass++;
    @(posedge clock_i); #1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    w = 0;
    while (!rsp0_valid_o && w < 30) begin @(posedge clock_i); #1; w++; end
    n_checks++; if (rsp0_valid_o !== 1'b1 || rsp_data_o !== 24'd6) $display("FAIL rst_tie_rsp: got %b/%0d expected 1/6", rsp0_valid_o, rsp_data_o); else n_pass++;
    finish_rsp(1'b0);
  endtask

  initial begin
    nreset_i     = 1'b0;
    req0_valid_i = 1'b0; req0_a_i = '0; req0_b_i = '0;
    req1_valid_i = 1'b0; req1_a_i = '0; req1_b_i = '0;
    rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
    test_reset();
    test_single();
    test_zero();
    test_max();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
